pe_row_scheduler: RTL
=====================

// Module: pe_row_scheduler
// PURPOSE
//  Sequencer for one PE (act RF, weight RF, fp FMA, row_sum). Per output row it fetches operands
//  over a req/ack handshake, then drives pe_en plus the count1/count2 RF indices, one MAC per
//  FMA_LAT cycles so each accumulate sees the previous partial sum. Pulses out_valid per finished
//  window and done per job. Sits between the tile buffer controller and the PE.
// PARAMETERS
//  CHANNEL  2   input channels per MAC window
//  NUM1     14  activations per row in the act RF
//  NUM2     5   kernel width; windows per row NWIN = NUM1+1-NUM2
//  FMA_LAT  3   fp FMA result latency in cycles, >=1
//  ROWW     8   width of the row counter
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous reset, active-high
//  start      in   1      job start pulse, sampled only in IDLE
//  num_rows   in   ROWW   rows in the job, latched on accepted start
//  abort      in   1      synchronous abort, returns to IDLE
//  ld_req     out  1      operand load request to the tile buffer
//  ld_w       out  1      1 = this load includes weights (first row only)
//  ld_ack     in   1      load complete; transfer when ld_req&ld_ack
//  pe_en      out  1      FMA issue strobe (tvalid of a/b/c)
//  count1     out  C1W    MAC index 0..CHANNEL*NUM2-1, C1W=$clog2(CHANNEL*NUM2)
//  count2     out  C2W    window index 0..NWIN-1, C2W=$clog2(NWIN)
//  out_valid  out  1      1-cycle pulse: window count2 result is final
//  row_idx    out  ROWW   current row, 0-based
//  busy       out  1      job in progress
//  done       out  1      1-cycle job-complete pulse
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; row_idx, count1 and count2 cleared.
//  FSM states: IDLE, LOAD, RUN, WAIT, EMIT, DONE.
//  IDLE: start=1 and num_rows!=0 -> latch num_rows, row_idx=0 -> LOAD.
//   start with num_rows==0 -> DONE. No load is issued.
//  LOAD: ld_req=1; ld_w=(row_idx==0). Stays until ld_ack=1 is sampled. Then -> RUN, count1=0, count2=0.
//   ld_ack outside LOAD is ignored.
//  RUN: pe_en=1 for exactly one cycle. -> WAIT if FMA_LAT>1, otherwise directly to the advance step.
//  WAIT: pe_en=0 for FMA_LAT-1 cycles. Then the advance step:
//   count1<last: count1++ -> RUN.
//   count1==last: -> EMIT.
//  EMIT: out_valid=1 for one cycle; count2 still holds the finished window. Then count1=0 and:
//   count2<NWIN-1: count2++ -> RUN.
//   else if row_idx<num_rows-1: row_idx++ -> LOAD.
//   else -> DONE.
//  DONE: done=1 for one cycle, busy=0 -> IDLE.
//  busy=1 in LOAD/RUN/WAIT/EMIT, 0 in IDLE/DONE. count1/count2 hold their values outside RUN/WAIT/EMIT.
//  Spacing: successive pe_en pulses are exactly FMA_LAT cycles apart within a window.
//  Window length: CHANNEL*NUM2*FMA_LAT+1 cycles. out_valid comes FMA_LAT cycles after the window's last pe_en.
//  start while busy: ignored; num_rows is not re-latched.
//  abort: any state -> IDLE next cycle. pe_en/ld_req/out_valid drop; done is not pulsed.
//   abort has priority over every transition, including a simultaneous start.
//  rst mid-job: immediate return to reset values. Any pending load handshake is dropped.
//  Counters compare against exact limits, never rely on power-of-2 wrap. num_rows latched value is used for all rows.
// TESTING (CHANNEL=2,NUM1=14,NUM2=5,FMA_LAT=3)
//  T1 start@c0, num_rows=1, ld_ack tied 1 -> ld_req c1 with ld_w=1; pe_en c2,5,..,29 (count1 0..9);
//     out_valid c32,63,..,311 (count2 0..9); done c312; 100 pe_en total.
//  T2 num_rows=3, ld_ack delayed 4 cycles each -> ld_req held 5 cycles per row; ld_w=1 row0 only;
//     30 out_valid; row_idx 0,1,2; single done.
//  T3 FMA_LAT=1 build -> pe_en continuous 10 cycles per window; out_valid 1 cycle after the window's last pe_en; no WAIT.
//  T4 abort during WAIT of window 4, row 1 -> IDLE next cycle; busy=0; no done. New start runs T1 timing.
//  T5 start with num_rows=0 -> done one cycle later; ld_req and pe_en never assert. start while busy -> no effect.
//  T6 rst asserted mid-RUN, asynchronously -> all outputs 0 without a clock edge; clean restart after release.

Source files
------------

// File: rtl/pe_row_scheduler.sv
// Row sequencer for a single PE: fetches operands per row, then issues one FMA
// every FMA_LAT cycles across every MAC of every window, flagging finished windows and jobs.
module pe_row_scheduler #(
    parameter int CHANNEL = 2,
    parameter int NUM1    = 14,
    parameter int NUM2    = 5,
    parameter int FMA_LAT = 3,
    parameter int ROWW    = 8,
    localparam int MACS   = CHANNEL * NUM2,
    localparam int NWIN   = NUM1 + 1 - NUM2,
    localparam int C1W    = (MACS > 1) ? $clog2(MACS) : 1,
    localparam int C2W    = (NWIN > 1) ? $clog2(NWIN) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [ROWW-1:0] num_rows,
    input  logic            abort,
    output logic            ld_req,
    output logic            ld_w,
    input  logic            ld_ack,
    output logic            pe_en,
    output logic [C1W-1:0]  count1,
    output logic [C2W-1:0]  count2,
    output logic            out_valid,
    output logic [ROWW-1:0] row_idx,
    output logic            busy,
    output logic            done
);

    // WAIT lasts FMA_LAT-1 cycles; the counter runs 0..FMA_LAT-2.
    localparam int WW = (FMA_LAT > 2) ? $clog2(FMA_LAT - 1) : 1;
    localparam logic [WW-1:0]  WAIT_LAST = WW'((FMA_LAT > 1) ? FMA_LAT - 2 : 0);
    localparam logic [C1W-1:0] C1_LAST   = C1W'(MACS - 1);
    localparam logic [C2W-1:0] C2_LAST   = C2W'(NWIN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_WAIT,
        S_EMIT,
        S_DONE
    } state_t;

    state_t          state, state_n;
    logic [C1W-1:0]  count1_n;
    logic [C2W-1:0]  count2_n;
    logic [ROWW-1:0] row_idx_n;
    logic [ROWW-1:0] rows_q, rows_n;
    logic [WW-1:0]   wait_cnt, wait_cnt_n;
    logic            advance;
    logic            more_rows;

    // Widened compare so num_rows of all-ones cannot overflow the row_idx+1 term.
    assign more_rows = ({1'b0, row_idx} + (ROWW + 1)'(1)) < {1'b0, rows_q};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            count1   <= '0;
            count2   <= '0;
            row_idx  <= '0;
            rows_q   <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_n;
            count1   <= count1_n;
            count2   <= count2_n;
            row_idx  <= row_idx_n;
            rows_q   <= rows_n;
            wait_cnt <= wait_cnt_n;
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_n    = state;
        count1_n   = count1;
        count2_n   = count2;
        row_idx_n  = row_idx;
        rows_n     = rows_q;
        wait_cnt_n = wait_cnt;
        advance    = 1'b0;
        ld_req     = 1'b0;
        ld_w       = 1'b0;
        pe_en      = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    if (num_rows != '0) begin
                        rows_n    = num_rows;
                        row_idx_n = '0;
                        state_n   = S_LOAD;
                    end else begin
                        state_n   = S_DONE;
                    end
                end
            end
            S_LOAD: begin
                ld_req = 1'b1;
                ld_w   = (row_idx == '0);
                busy   = 1'b1;
                if (ld_ack) begin
                    count1_n = '0;
                    count2_n = '0;
                    state_n  = S_RUN;
                end
            end
            S_RUN: begin
                pe_en      = 1'b1;
                busy       = 1'b1;
                wait_cnt_n = '0;
                if (FMA_LAT > 1) state_n = S_WAIT;
                else             advance = 1'b1;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (wait_cnt == WAIT_LAST) advance = 1'b1;
                else                       wait_cnt_n = wait_cnt + WW'(1);
            end
            S_EMIT: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                count1_n  = '0;
                if (count2 < C2_LAST) begin
                    count2_n = count2 + C2W'(1);
                    state_n  = S_RUN;
                end else if (more_rows) begin
                    row_idx_n = row_idx + ROWW'(1);
                    state_n   = S_LOAD;
                end else begin
                    state_n   = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        // The previous partial sum is now available: issue the next MAC or close the window.
        if (advance) begin
            if (count1 < C1_LAST) begin
                count1_n = count1 + C1W'(1);
                state_n  = S_RUN;
            end else begin
                state_n  = S_EMIT;
            end
        end

        // Abort beats every transition, including a start seen in IDLE; counters hold.
        if (abort) begin
            state_n   = S_IDLE;
            count1_n  = count1;
            count2_n  = count2;
            row_idx_n = row_idx;
            rows_n    = rows_q;
        end
    end

endmodule
